kalman_alu4: RTL and testbench
==============================

# kalman_alu4

Kalman filter step 4: state update. Takes the innovation word from the step-3 measurement stage and the Kalman gains from the gain stage. Produces the corrected angle and gyro bias:
- angle = angle + K0·y
- bias = bias + K1·y

Both gain products are formed with a shared-control, 16-cycle serial shift-add multiplier. A start/done handshake ties the block into the filter sequencer. Its outputs feed step 1 of the next filter iteration.

## Interface
Parameters:
- none

Ports:
- clk, input, 1: system clock; all state on rising edge.
- rst, input, 1: synchronous, active-high reset.
- start, input, 1: one-cycle request; sampled only in IDLE.
- angle_in, input, 16: predicted angle from step 1, unsigned.
- bias_in, input, 16: current gyro bias, two's complement.
- y_in, input, 16: innovation from step 3.
  - [15:1] is magnitude m.
  - [0] is sign s: 1 means prediction > measurement (negative); 0 means non-negative.
- k0_in, input, 16: angle gain, unsigned Q0.16.
- k1_in, input, 16: bias gain, unsigned Q0.16.
- angle_out, output, 16: updated angle, unsigned, registered.
- bias_out, output, 16: updated bias, two's complement, registered.
- busy, output, 1: high while a computation is in progress.
- done, output, 1: one-cycle pulse; outputs are valid from this cycle.

## Operation
- Delta: d = {m, 1'b0}, a 16-bit unsigned value.
- Corrections:
  - c0 = floor(d·k0_in / 2^16)
  - c1 = floor(d·k1_in / 2^16)
  - Both are exact 16-bit results, i.e. bits [31:16] of the 32-bit product.
- Angle update:
  - s=0: angle_out = min(angle_in + c0, 0xFFFF).
  - s=1: angle_out = max(angle_in − c0, 0).
  - Compute in 17 bits, then clamp.
- Bias update:
  - s=0: bias_out = bias_in + c1; s=1: bias_out = bias_in − c1.
  - Compute in 18-bit signed; clamp to the range [0x8000, 0x7FFF].
- Multiplier:
  - Two 32-bit accumulators run in lockstep, driven by the same d bits, LSB first.
  - Each cycle, add k (into the upper half) if the current d bit is 1, then shift right one.
- All operands (angle_in, bias_in, y_in, k0_in, k1_in) are latched at the start edge. Later input changes do not affect the result.
- FSM states:
  - IDLE: busy=0. On start=1, latch operands, clear the accumulators and the 4-bit counter, go to MULT.
  - MULT: busy=1. Process one d bit per clock. After the 16th bit (counter = 15), go to UPDATE.
  - UPDATE: busy=1. Compute the saturated results, register angle_out and bias_out, assert done for the next cycle, go to IDLE.
- start while busy=1 is ignored. It is not queued.
- Outputs hold their last value until the next UPDATE.

## Timing
- Edge E0 samples start=1 in IDLE. MULT occupies edges E1–E16; UPDATE is edge E17.
- After E17: angle_out and bias_out hold the new values, and done=1 for exactly one cycle (sampled at E18). busy=0 in that same cycle.
- busy is high for 17 cycles, covering the cycles after E0 through E16.
- Throughput: a new start is accepted in the done cycle, so back-to-back operations are 18 cycles apart.
- Reset values: angle_out=0x0000, bias_out=0x0000, busy=0, done=0, FSM in IDLE, counter=0.
- rst mid-operation aborts at that edge: no done is generated, and outputs go to 0.
- rst wins over simultaneous start.
- Boundaries:
  - m=0, or gain=0: the output equals the latched input exactly, regardless of s (y_in=0x0001 is a no-op).
  - Saturation applies only to the final sum. Corrections are never truncated beyond the floor.

## Test plan
- Positive innovation, nominal:
  - Stimulus: angle_in=0x4000, bias_in=0x0010, y_in=0x0100, k0=0x8000, k1=0x4000.
  - Required: angle_out=0x4080, bias_out=0x0050, done exactly 18 edges after the start edge, busy high for 17 cycles.
- Negative innovation:
  - Stimulus: same operands as above, but y_in=0x0101.
  - Required: angle_out=0x3F80, bias_out=0xFFD0.
- Upper saturation:
  - Stimulus: angle_in=0xFFF0, bias_in=0x7FF0, y_in=0xFFFE, k0=k1=0xFFFF (c0=c1=0xFFFD).
  - Required: angle_out=0xFFFF, bias_out=0x7FFF.
- Lower saturation:
  - Stimulus: angle_in=0x0010, bias_in=0x8010, y_in=0xFFFF, k0=k1=0xFFFF.
  - Required: angle_out=0x0000, bias_out=0x8000.
- Handshake:
  - Stimulus: change all inputs and pulse start during MULT.
  - Required: result matches the operands latched at the original start; the second start is ignored; only one done pulse.
  - Stimulus: start issued in the done cycle.
  - Required: accepted.
- Reset:
  - Stimulus: assert rst at edge E8 of an operation.
  - Required: next cycle busy=0, done=0, angle_out=bias_out=0, FSM idle; no done appears afterwards.
  - Stimulus: a fresh start after reset.
  - Required: completes normally.

Source files
------------

// File: rtl/kalman_alu4.sv
// Kalman filter step 4: state update (angle += K0*y, bias += K1*y).
// Both gain products share one 16-cycle LSB-first shift-add sequence.
module kalman_alu4 (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] angle_in,
  input  logic [15:0] bias_in,
  input  logic [15:0] y_in,
  input  logic [15:0] k0_in,
  input  logic [15:0] k1_in,
  output logic [15:0] angle_out,
  output logic [15:0] bias_out,
  output logic        busy,
  output logic        done
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    MULT   = 2'd1,
    UPDATE = 2'd2
  } state_t;

  localparam logic signed [17:0] BIAS_MAX = 18'sd32767;
  localparam logic signed [17:0] BIAS_MIN = -18'sd32768;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [15:0] angle_op_q, angle_op_d;
  logic [15:0] bias_op_q, bias_op_d;
  logic [15:0] d_q, d_d;
  logic        sign_q, sign_d;
  logic [15:0] k0_q, k0_d;
  logic [15:0] k1_q, k1_d;
  logic [31:0] acc0_q, acc0_d;
  logic [31:0] acc1_q, acc1_d;
  logic [15:0] angle_out_q, angle_out_d;
  logic [15:0] bias_out_q, bias_out_d;
  logic        done_q, done_d;

  // Shift-add step: 33-bit sum keeps the carry before the right shift.
  logic [32:0] add0, add1;
  assign add0 = {1'b0, acc0_q} + {1'b0, (d_q[0] ? k0_q : 16'h0000), 16'h0000};
  assign add1 = {1'b0, acc1_q} + {1'b0, (d_q[0] ? k1_q : 16'h0000), 16'h0000};

  logic [15:0] c0, c1;
  assign c0 = acc0_q[31:16];
  assign c1 = acc1_q[31:16];

  logic [16:0] ang_sum, ang_dif;
  logic [15:0] ang_new;
  assign ang_sum = {1'b0, angle_op_q} + {1'b0, c0};
  assign ang_dif = {1'b0, angle_op_q} - {1'b0, c0};

  always_comb begin
    ang_new = '0;
    if (sign_q) ang_new = ang_dif[16] ? 16'h0000 : ang_dif[15:0];
    else        ang_new = ang_sum[16] ? 16'hFFFF : ang_sum[15:0];
  end

  logic signed [17:0] b_ext, c1_ext, b_res;
  logic [15:0]        bias_new;
  assign b_ext  = {{2{bias_op_q[15]}}, bias_op_q};
  assign c1_ext = {2'b00, c1};
  assign b_res  = sign_q ? (b_ext - c1_ext) : (b_ext + c1_ext);

  always_comb begin
    bias_new = b_res[15:0];
    if (b_res > BIAS_MAX)      bias_new = 16'h7FFF;
    else if (b_res < BIAS_MIN) bias_new = 16'h8000;
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    angle_op_d  = angle_op_q;
    bias_op_d   = bias_op_q;
    d_d         = d_q;
    sign_d      = sign_q;
    k0_d        = k0_q;
    k1_d        = k1_q;
    acc0_d      = acc0_q;
    acc1_d      = acc1_q;
    angle_out_d = angle_out_q;
    bias_out_d  = bias_out_q;
    done_d      = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          angle_op_d = angle_in;
          bias_op_d  = bias_in;
          d_d        = {y_in[15:1], 1'b0};
          sign_d     = y_in[0];
          k0_d       = k0_in;
          k1_d       = k1_in;
          acc0_d     = '0;
          acc1_d     = '0;
          cnt_d      = '0;
          state_d    = MULT;
        end
      end
      MULT: begin
        acc0_d = add0[32:1];
        acc1_d = add1[32:1];
        d_d    = d_q >> 1;
        cnt_d  = cnt_q + 4'd1;
        if (cnt_q == 4'd15) state_d = UPDATE;
      end
      UPDATE: begin
        angle_out_d = ang_new;
        bias_out_d  = bias_new;
        done_d      = 1'b1;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      angle_op_q  <= '0;
      bias_op_q   <= '0;
      d_q         <= '0;
      sign_q      <= 1'b0;
      k0_q        <= '0;
      k1_q        <= '0;
      acc0_q      <= '0;
      acc1_q      <= '0;
      angle_out_q <= '0;
      bias_out_q  <= '0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      angle_op_q  <= angle_op_d;
      bias_op_q   <= bias_op_d;
      d_q         <= d_d;
      sign_q      <= sign_d;
      k0_q        <= k0_d;
      k1_q        <= k1_d;
      acc0_q      <= acc0_d;
      acc1_q      <= acc1_d;
      angle_out_q <= angle_out_d;
      bias_out_q  <= bias_out_d;
      done_q      <= done_d;
    end
  end

  assign angle_out = angle_out_q;
  assign bias_out  = bias_out_q;
  assign busy      = (state_q != IDLE);
  assign done      = done_q;

endmodule

// File: tb/tb_kalman_alu4.sv
// Directed-vector bench for kalman_alu4; inputs change and outputs are sampled on falling edges.
module tb_kalman_alu4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [15:0] angle_in = '0, bias_in = '0, y_in = '0, k0_in = '0, k1_in = '0;
  logic [15:0] angle_out, bias_out;
  logic        busy, done;

  int pass_cnt = 0;
  int total_cnt = 0;

  kalman_alu4 dut (
    .clk(clk), .rst(rst), .start(start),
    .angle_in(angle_in), .bias_in(bias_in), .y_in(y_in),
    .k0_in(k0_in), .k1_in(k1_in),
    .angle_out(angle_out), .bias_out(bias_out),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Issue one operation; lat counts falling edges from the one after the start edge to done.
  task automatic run_op(input logic [15:0] a, b, y, g0, g1,
                        output int lat, output int bcnt, output logic bz);
    @(negedge clk);
    angle_in = a; bias_in = b; y_in = y; k0_in = g0; k1_in = g1; start = 1'b1;
    @(negedge clk);
    start = 1'b0; lat = 0; bcnt = 0;
    while (done !== 1'b1 && lat < 40) begin
      if (busy === 1'b1) bcnt++;
      @(negedge clk);
      lat++;
    end
    bz = busy;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    total_cnt++; if (angle_out !== 16'h0000) $display("FAIL reset_angle got %h exp %h", angle_out, 16'h0000); else pass_cnt++;
    total_cnt++; if (bias_out !== 16'h0000) $display("FAIL reset_bias got %h exp %h", bias_out, 16'h0000); else pass_cnt++;
    total_cnt++; if (busy !== 1'b0) $display("FAIL reset_busy got %b exp 0", busy); else pass_cnt++;
    total_cnt++; if (done !== 1'b0) $display("FAIL reset_done got %b exp 0", done); else pass_cnt++;
    rst = 1'b0;
  endtask

  task automatic test_nominal();
    int lat, bcnt; logic bz;
    run_op(16'h4000, 16'h0010, 16'h0100, 16'h8000, 16'h4000, lat, bcnt, bz);
    total_cnt++; if (lat !== 17) $display("FAIL nom_latency got %0d exp 17", lat); else pass_cnt++;
    total_cnt++; if (bcnt !== 17) $display("FAIL nom_busy_cycles got %0d exp 17", bcnt); else pass_cnt++;
    total_cnt++; if (bz !== 1'b0) $display("FAIL nom_busy_at_done got %b exp 0", bz); else pass_cnt++;
    total_cnt++; if (angle_out !== 16'h4080) $display("FAIL nom_angle got %h exp %h", angle_out, 16'h4080); else pass_cnt++;
    total_cnt++; if (bias_out !== 16'h0050) $display("FAIL nom_bias got %h exp %h", bias_out, 16'h0050); else pass_cnt++;
    @(negedge clk);
    total_cnt++; if (done !== 1'b0) $display("FAIL nom_done_width got %b exp 0", done); else pass_cnt++;
    total_cnt++; if (angle_out !== 16'h4080) $display("FAIL nom_angle_hold got %h exp %h", angle_out, 16'h4080); else pass_cnt++;
  endtask

  task automatic test_negative();
    int lat, bcnt; logic bz;
    run_op(16'h4000, 16'h0010, 16'h0101, 16'h8000, 16'h4000, lat, bcnt, bz);
    total_cnt++; if (lat !== 17) $display("FAIL neg_latency got %0d exp 17", lat); else pass_cnt++;
    total_cnt++; if (angle_out !== 16'h3F80) $display("FAIL neg_angle got %h exp %h", angle_out, 16'h3F80); else pass_cnt++;
    total_cnt++; if (bias_out !== 16'hFFD0) $display("FAIL neg_bias got %h exp %h", bias_out, 16'hFFD0); else pass_cnt++;
  endtask

  task automatic test_saturation();
    int lat, bcnt; logic bz;
    run_op(16'hFFF0, 16'h7FF0, 16'hFFFE, 16'hFFFF, 16'hFFFF, lat, bcnt, bz);
    total_cnt++; if (angle_out !== 16'hFFFF) $display("FAIL sat_hi_angle got %h exp %h", angle_out, 16'hFFFF); else pass_cnt++;
    total_cnt++; if (bias_out !== 16'h7FFF) $display("FAIL sat_hi_bias got %h exp %h", bias_out, 16'h7FFF); else pass_cnt++;
    run_op(16'h0010, 16'h8010, 16'hFFFF, 16'hFFFF, 16'hFFFF, lat, bcnt, bz);
    total_cnt++; if (angle_out !== 16'h0000) $display("FAIL sat_lo_angle got %h exp %h", angle_out, 16'h0000); else pass_cnt++;
    total_cnt++; if (bias_out !== 16'h8000) $display("FAIL sat_lo_bias got %h exp %h", bias_out, 16'h8000); else pass_cnt++;
  endtask

  task automatic test_boundaries();
    int lat, bcnt; logic bz;
    // m=0 with full gains and s=1: no-op
    run_op(16'h1234, 16'hFEDC, 16'h0001, 16'hFFFF, 16'hFFFF, lat, bcnt, bz);
    total_cnt++; if (angle_out !== 16'h1234) $display("FAIL m0_angle got %h exp %h", angle_out, 16'h1234); else pass_cnt++;
    total_cnt++; if (bias_out !== 16'hFEDC) $display("FAIL m0_bias got %h exp %h", bias_out, 16'hFEDC); else pass_cnt++;
    // zero gains with a large innovation
    run_op(16'hABCD, 16'h0123, 16'h8000, 16'h0000, 16'h0000, lat, bcnt, bz);
    total_cnt++; if (angle_out !== 16'hABCD) $display("FAIL k0_angle got %h exp %h", angle_out, 16'hABCD); else pass_cnt++;
    total_cnt++; if (bias_out !== 16'h0123) $display("FAIL k0_bias got %h exp %h", bias_out, 16'h0123); else pass_cnt++;
    // d=2: c0 = floor(2*0xFFFF/65536)=1, c1 = floor(2*0x8000/65536)=1
    run_op(16'h1234, 16'hFEDC, 16'h0003, 16'hFFFF, 16'h8000, lat, bcnt, bz);
    total_cnt++; if (angle_out !== 16'h1233) $display("FAIL floor_angle got %h exp %h", angle_out, 16'h1233); else pass_cnt++;
    total_cnt++; if (bias_out !== 16'hFEDB) $display("FAIL floor_bias got %h exp %h", bias_out, 16'hFEDB); else pass_cnt++;
  endtask

  task automatic test_handshake();
    int pulses; logic [15:0] a_got, b_got;
    @(negedge clk);
    angle_in = 16'h4000; bias_in = 16'h0010; y_in = 16'h0100; k0_in = 16'h8000; k1_in = 16'h4000; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    angle_in = 16'hFFF0; bias_in = 16'h7FF0; y_in = 16'hFFFE; k0_in = 16'hFFFF; k1_in = 16'hFFFF; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    pulses = 0; a_got = '0; b_got = '0;
    for (int i = 0; i < 40; i++) begin
      if (done === 1'b1) begin
        if (pulses == 0) begin a_got = angle_out; b_got = bias_out; end
        pulses++;
      end
      @(negedge clk);
    end
    total_cnt++; if (pulses !== 1) $display("FAIL hs_done_pulses got %0d exp 1", pulses); else pass_cnt++;
    total_cnt++; if (a_got !== 16'h4080) $display("FAIL hs_angle got %h exp %h", a_got, 16'h4080); else pass_cnt++;
    total_cnt++; if (b_got !== 16'h0050) $display("FAIL hs_bias got %h exp %h", b_got, 16'h0050); else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    int lat, bcnt; logic bz;
    run_op(16'h4000, 16'h0010, 16'h0101, 16'h8000, 16'h4000, lat, bcnt, bz);
    total_cnt++; if (angle_out !== 16'h3F80) $display("FAIL b2b_first_angle got %h exp %h", angle_out, 16'h3F80); else pass_cnt++;
    angle_in = 16'h4000; bias_in = 16'h0010; y_in = 16'h0100; k0_in = 16'h8000; k1_in = 16'h4000; start = 1'b1;
    @(negedge clk);
    start = 1'b0; lat = 0;
    while (done !== 1'b1 && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    total_cnt++; if (lat !== 17) $display("FAIL b2b_latency got %0d exp 17", lat); else pass_cnt++;
    total_cnt++; if (angle_out !== 16'h4080) $display("FAIL b2b_angle got %h exp %h", angle_out, 16'h4080); else pass_cnt++;
    total_cnt++; if (bias_out !== 16'h0050) $display("FAIL b2b_bias got %h exp %h", bias_out, 16'h0050); else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    int lat, bcnt, pulses; logic bz;
    @(negedge clk);
    angle_in = 16'hFFF0; bias_in = 16'h7FF0; y_in = 16'hFFFE; k0_in = 16'hFFFF; k1_in = 16'hFFFF; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (7) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    total_cnt++; if (busy !== 1'b0) $display("FAIL rmid_busy got %b exp 0", busy); else pass_cnt++;
    total_cnt++; if (done !== 1'b0) $display("FAIL rmid_done got %b exp 0", done); else pass_cnt++;
    total_cnt++; if (angle_out !== 16'h0000) $display("FAIL rmid_angle got %h exp %h", angle_out, 16'h0000); else pass_cnt++;
    total_cnt++; if (bias_out !== 16'h0000) $display("FAIL rmid_bias got %h exp %h", bias_out, 16'h0000); else pass_cnt++;
    rst = 1'b0;
    pulses = 0;
    for (int i = 0; i < 30; i++) begin
      if (done === 1'b1 || busy === 1'b1) pulses++;
      @(negedge clk);
    end
    total_cnt++; if (pulses !== 0) $display("FAIL rmid_no_activity got %0d exp 0", pulses); else pass_cnt++;
    rst = 1'b1; start = 1'b1;
    @(negedge clk);
    rst = 1'b0; start = 1'b0;
    total_cnt++; if (busy !== 1'b0) $display("FAIL rst_over_start got %b exp 0", busy); else pass_cnt++;
    run_op(16'h0010, 16'h8010, 16'hFFFF, 16'hFFFF, 16'hFFFF, lat, bcnt, bz);
    total_cnt++; if (lat !== 17) $display("FAIL post_rst_latency got %0d exp 17", lat); else pass_cnt++;
    total_cnt++; if (bias_out !== 16'h8000) $display("FAIL post_rst_bias got %h exp %h", bias_out, 16'h8000); else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_negative();
    test_saturation();
    test_boundaries();
    test_handshake();
    test_back_to_back();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
